credit_rr_scheduler: RTL and testbench

//  Consumer side of the per-channel credit counter array (array_counter_v3).
//  - Reads the N credit counts.
//  - Picks one requesting channel per cycle by round-robin, among channels whose credit is non-zero.
//  - Returns the consumed credit through dec/dec_id.
//  - Presents the granted channel id on a registered valid/ready output stage.

---
 rtl/credit_rr_scheduler.sv | 76 +++++++
 tb/tb_credit_rr_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_rr_scheduler.sv
// Round-robin scheduler over credited channels: grants one eligible requester per
// cycle, returns the consumed credit and presents the granted id on a registered stage.
module credit_rr_scheduler #(
   parameter int W   = 6,
   parameter int N   = 2,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   cnt [N],
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   output logic           dec,
   output logic [IDW-1:0] dec_id,
   output logic           out_valid,
   output logic [IDW-1:0] out_id,
   input  logic           out_ready
);

   logic [N-1:0]   elig;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] sel;
   logic           found;
   logic           load;
   logic           grant;
   logic [IDW:0]   idx;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         elig[i] = req_valid[i] && (cnt[i] != '0);
      end
   end

   // Scan starts at rr_ptr and wraps at N; the extra idx bit holds rr_ptr+k before the wrap.
   always_comb begin
      sel   = rr_ptr;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(N)) begin
            idx = idx - (IDW+1)'(N);
         end
         if (!found && elig[idx[IDW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IDW-1:0];
         end
      end
   end

   assign load = !out_valid || out_ready;

   // NOTE: rst gates the combinational grant so req_ready/dec stay low while reset is held.
   assign grant = !rst && load && found;

   assign req_ready = grant ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
   assign dec       = grant;
   // out_id always carries the most recent grant, which is exactly the value dec_id holds.
   assign dec_id    = grant ? sel : out_id;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_id    <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         out_valid <= 1'b1;
         out_id    <= sel;
         rr_ptr    <= (sel == IDW'(N-1)) ? '0 : sel + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_credit_rr_scheduler.sv
// Bench for credit_rr_scheduler: an N=2 instance for directed scenarios and an N=3
// instance for non-power-of-two wrap, both checked every cycle against a queue-based model.
module tb_credit_rr_scheduler;

   localparam int W = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [W-1:0] cnt_a [2];
   logic [1:0]   rv_a, rr_a;
   logic         dec_a, ov_a, ordy_a;
   logic [0:0]   decid_a, oid_a;

   logic [W-1:0] cnt_b [3];
   logic [2:0]   rv_b, rr_b;
   logic         dec_b, ov_b, ordy_b;
   logic [1:0]   decid_b, oid_b;

   credit_rr_scheduler #(.W(W), .N(2)) dut_a (
      .clk(clk), .rst(rst), .cnt(cnt_a), .req_valid(rv_a), .req_ready(rr_a),
      .dec(dec_a), .dec_id(decid_a), .out_valid(ov_a), .out_id(oid_a), .out_ready(ordy_a)
   );

   credit_rr_scheduler #(.W(W), .N(3)) dut_b (
      .clk(clk), .rst(rst), .cnt(cnt_b), .req_valid(rv_b), .req_ready(rr_b),
      .dec(dec_b), .dec_id(decid_b), .out_valid(ov_b), .out_id(oid_b), .out_ready(ordy_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = dut_a, 1 = dut_b.
   int         nch [2] = '{2, 3};
   int         m_cnt [2][3];
   int         m_inc [2][3];
   logic [2:0] m_req [2];
   logic       m_ordy [2];
   logic       m_valid [2];
   int         m_id [2];
   int         m_ptr [2];
   int         g_exp [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Channels are visited in round-robin order starting from the pointer.
   function automatic int pick(input int k);
      int order[$];
      if (m_valid[k] && !m_ordy[k]) return -1;
      for (int i = 0; i < nch[k]; i++) order.push_back((m_ptr[k] + i) % nch[k]);
      foreach (order[j]) begin
         if (m_req[k][order[j]] && m_cnt[k][order[j]] > 0) return order[j];
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_id[k]    = 0;
         m_ptr[k]   = 0;
      end
   endtask

   task automatic check_inst(input int k, input logic [2:0] rr, input logic dc,
                             input logic [1:0] did, input logic ov, input logic [1:0] oid);
      int g;
      g = g_exp[k];
      check($sformatf("req_ready[%0d]", k), {29'd0, rr}, (g >= 0) ? (32'd1 << g) : 32'd0);
      check($sformatf("dec[%0d]", k), {31'd0, dc}, (g >= 0) ? 32'd1 : 32'd0);
      check($sformatf("dec_id[%0d]", k), {30'd0, did}, (g >= 0) ? g : m_id[k]);
      check($sformatf("out_valid[%0d]", k), {31'd0, ov}, {31'd0, m_valid[k]});
      check($sformatf("out_id[%0d]", k), {30'd0, oid}, m_id[k]);
   endtask

   // Drive inputs from the model, then check combinational and registered outputs mid-cycle.
   task automatic drive_check();
      rv_a   = m_req[0][1:0];
      ordy_a = m_ordy[0];
      rv_b   = m_req[1];
      ordy_b = m_ordy[1];
      for (int i = 0; i < 2; i++) cnt_a[i] = W'(m_cnt[0][i]);
      for (int i = 0; i < 3; i++) cnt_b[i] = W'(m_cnt[1][i]);
      #1;
      for (int k = 0; k < 2; k++) g_exp[k] = pick(k);
      check_inst(0, {1'b0, rr_a}, dec_a, {1'b0, decid_a}, ov_a, {1'b0, oid_a});
      check_inst(1, rr_b, dec_b, decid_b, ov_b, oid_b);
   endtask

   task automatic advance();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (g_exp[k] >= 0) begin
            m_valid[k] = 1'b1;
            m_id[k]    = g_exp[k];
            m_ptr[k]   = (g_exp[k] + 1) % nch[k];
            m_cnt[k][g_exp[k]]--;
         end else if (m_ordy[k]) begin
            m_valid[k] = 1'b0;
         end
         for (int i = 0; i < 3; i++) begin
            m_cnt[k][i] += m_inc[k][i];
            m_inc[k][i] = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      drive_check();
      advance();
   endtask

   task automatic set_a(input logic [1:0] req, input logic rdy, input int c0, input int c1);
      m_req[0]    = {1'b0, req};
      m_ordy[0]   = rdy;
      m_cnt[0][0] = c0;
      m_cnt[0][1] = c1;
   endtask

   int n_g1, n_g0;

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            m_cnt[k][i] = 0;
            m_inc[k][i] = 0;
         end
         m_req[k]  = '0;
         m_ordy[k] = 1'b1;
         g_exp[k]  = -1;
      end
      model_reset();

      // 1: reset held with all channels requesting and credited
      rst = 1'b1;
      rv_a = 2'b11; ordy_a = 1'b1; cnt_a[0] = 6'd3; cnt_a[1] = 6'd3;
      rv_b = 3'b111; ordy_b = 1'b1;
      for (int i = 0; i < 3; i++) cnt_b[i] = 6'd3;
      #1;
      check("rst_out_valid", {31'd0, ov_a}, 0);
      check("rst_req_ready", {30'd0, rr_a}, 0);
      check("rst_dec", {31'd0, dec_a}, 0);
      check("rst_dec_b", {31'd0, dec_b}, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_held_out_valid", {31'd0, ov_a}, 0);
      check("rst_held_req_ready", {30'd0, rr_a}, 0);
      rst = 1'b0;

      // 2: alternating grants drain {3,3}
      set_a(2'b11, 1'b1, 3, 3);
      for (int c = 0; c < 6; c++) begin
         drive_check();
         check($sformatf("t2_dec_id_%0d", c), {31'd0, decid_a}, c % 2);
         advance();
         check($sformatf("t2_out_id_%0d", c), {31'd0, oid_a}, c % 2);
         check($sformatf("t2_out_valid_%0d", c), {31'd0, ov_a}, 1);
      end
      check("t2_cnt0_zero", m_cnt[0][0], 0);
      check("t2_cnt1_zero", m_cnt[0][1], 0);
      step();
      check("t2_drained", {31'd0, ov_a}, 0);
      drive_check();
      check("t2_idle_dec", {31'd0, dec_a}, 0);
      advance();

      // 3: only channel 1 holds credit
      set_a(2'b11, 1'b1, 0, 2);
      n_g1 = 0; n_g0 = 0;
      for (int c = 0; c < 4; c++) begin
         drive_check();
         if (dec_a && decid_a == 1'b1) n_g1++;
         if (dec_a && decid_a == 1'b0) n_g0++;
         advance();
      end
      check("t3_grants_ch1", n_g1, 2);
      check("t3_grants_ch0", n_g0, 0);

      // 4: downstream stall holds the stage
      set_a(2'b11, 1'b1, 2, 2);
      step();
      m_ordy[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive_check();
         check("t4_hold_dec", {31'd0, dec_a}, 0);
         check("t4_hold_ready", {30'd0, rr_a}, 0);
         check("t4_hold_valid", {31'd0, ov_a}, 1);
         check("t4_hold_id", {31'd0, oid_a}, 0);
         advance();
      end
      m_ordy[0] = 1'b1;
      drive_check();
      check("t4_resume_dec", {31'd0, dec_a}, 1);
      check("t4_resume_id", {31'd0, decid_a}, 1);
      advance();

      // 5: pointer at 1 wraps back to channel 0
      set_a(2'b01, 1'b1, 4, 0);
      step();
      m_cnt[0][0] = 4;
      drive_check();
      check("t5_wrap_dec", {31'd0, dec_a}, 1);
      check("t5_wrap_id", {31'd0, decid_a}, 0);
      advance();

      // 6: reset with a held output
      set_a(2'b11, 1'b0, 2, 2);
      drive_check();
      check("t6_pre_valid", {31'd0, ov_a}, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_valid", {31'd0, ov_a}, 0);
      check("t6_rst_dec", {31'd0, dec_a}, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      set_a(2'b11, 1'b1, 2, 2);
      drive_check();
      check("t6_restart_dec", {31'd0, dec_a}, 1);
      check("t6_restart_id", {31'd0, decid_a}, 0);
      advance();

      // Randomized traffic on both instances
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 3; i++) m_cnt[k][i] = $urandom_range(0, 3);
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            m_req[k]  = 3'($urandom_range(0, 7));
            m_ordy[k] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++)
               m_inc[k][i] = ($urandom_range(0, 3) == 0 && m_cnt[k][i] < 60) ? 1 : 0;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
